// File: rtl/gpr_dump.sv
// gpr_dump -- sequential read-out engine for the picoMIPS register file.
//
// On a start pulse the block walks register numbers first_no..last_no
// (wrapping modulo 32). For each one it drives the number onto the register
// file's read address, captures the combinational read data, and offers the
// word on a valid/ready stream. The register file is never written.
//
// Optional feature (macro GPR_DUMP_CHECKSUM_EN): after the last data word an
// extra SUM word is streamed. It carries the 2^N-wrapped sum of every emitted
// word, and out_last moves onto that word.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous, active-high reset
//   start_i      begin a dump (only honoured in IDLE)
//   first_no_i   first register number, sampled with start_i
//   last_no_i    last register number, sampled with start_i
//   rd_no_o      read address to the register file
//   rd_data_i    combinational read data from the register file
//   out_data_o   streamed register value (or checksum)
//   out_no_o     register number belonging to out_data_o
//   out_valid_o  stream word valid
//   out_ready_i  consumer ready
//   out_last_o   final word of the dump
//   busy_o       block is not idle
//   done_o       one-cycle pulse after the final word is accepted
//
// States:
//   IDLE  | waiting for start_i
//   FETCH | rd_no_o = ptr, capture read data
//   SEND  | present captured word, wait for out_ready_i
//   SUM   | present checksum word (macro builds only)
//   DONE  | one-cycle done pulse
module gpr_dump #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [4:0]   first_no_i,
  input  logic [4:0]   last_no_i,
  output logic [4:0]   rd_no_o,
  input  logic [N-1:0] rd_data_i,
  output logic [N-1:0] out_data_o,
  output logic [4:0]   out_no_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         out_last_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_SUM   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [4:0]   ptr_q, ptr_d;
  logic [4:0]   end_q, end_d;
  logic [N-1:0] data_q, data_d;
  logic [4:0]   no_q, no_d;
`ifdef GPR_DUMP_CHECKSUM_EN
  logic [N-1:0] acc_q, acc_d;
`endif

  logic at_end;
  logic accept;

  assign at_end = (ptr_q == end_q);
  assign accept = out_valid_o && out_ready_i;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_FETCH;
      S_FETCH: state_d = S_SEND;
      S_SEND: begin
        if (out_ready_i) begin
          if (at_end) begin
`ifdef GPR_DUMP_CHECKSUM_EN
            state_d = S_SUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_SUM:   if (out_ready_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    busy_o      = (state_q != S_IDLE);
    done_o      = 1'b0;
    case (state_q)
      S_SEND: begin
        out_valid_o = 1'b1;
`ifdef GPR_DUMP_CHECKSUM_EN
        out_last_o  = 1'b0;
`else
        out_last_o  = at_end;
`endif
      end
      S_SUM: begin
        out_valid_o = 1'b1;
        out_last_o  = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    ptr_d  = ptr_q;
    end_d  = end_q;
    data_d = data_q;
    no_d   = no_q;
`ifdef GPR_DUMP_CHECKSUM_EN
    acc_d  = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ptr_d = first_no_i;
          end_d = last_no_i;
`ifdef GPR_DUMP_CHECKSUM_EN
          acc_d = '0;
`endif
        end
      end
      S_FETCH: begin
        data_d = rd_data_i;
        no_d   = ptr_q;
`ifdef GPR_DUMP_CHECKSUM_EN
        acc_d  = acc_q + rd_data_i;
`endif
      end
      S_SEND: begin
        if (accept) begin
          if (!at_end) begin
            ptr_d = ptr_q + 5'd1;  // 5-bit add wraps 31 -> 0
          end else begin
`ifdef GPR_DUMP_CHECKSUM_EN
            // Checksum word reuses the output holding registers.
            data_d = acc_q;
            no_d   = end_q;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q  <= '0;
      end_q  <= '0;
      data_q <= '0;
      no_q   <= '0;
`ifdef GPR_DUMP_CHECKSUM_EN
      acc_q  <= '0;
`endif
    end else begin
      ptr_q  <= ptr_d;
      end_q  <= end_d;
      data_q <= data_d;
      no_q   <= no_d;
`ifdef GPR_DUMP_CHECKSUM_EN
      acc_q  <= acc_d;
`endif
    end
  end

  assign rd_no_o    = ptr_q;
  assign out_data_o = data_q;
  assign out_no_o   = no_q;

endmodule

// File: tb/tb_gpr_dump.sv
module tb_gpr_dump;
  localparam int N     = 8;
  localparam int LIMIT = 2000;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         start_i;
  logic [4:0]   first_no_i, last_no_i;
  logic [4:0]   rd_no_o;
  logic [N-1:0] rd_data_i;
  logic [N-1:0] out_data_o;
  logic [4:0]   out_no_o;
  logic         out_valid_o, out_ready_i, out_last_o, busy_o, done_o;

  logic [N-1:0] regs [32];
  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  // Register file model: combinational read
  assign rd_data_i = regs[rd_no_o];

  gpr_dump #(.N(N)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .first_no_i (first_no_i),
    .last_no_i  (last_no_i),
    .rd_no_o    (rd_no_o),
    .rd_data_i  (rd_data_i),
    .out_data_o (out_data_o),
    .out_no_o   (out_no_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_last_o (out_last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_no"}, rd_no_o, 0);
    chk({tag, "_data"}, out_data_o, 0);
    chk({tag, "_no"}, out_no_o, 0);
    chk({tag, "_valid"}, out_valid_o, 0);
    chk({tag, "_last"}, out_last_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  // Runs one dump and checks the stream against the expected word list.
  // stall_idx/stall_len: hold ready low for stall_len cycles on that word.
  // rnd: random ready. poke: pulse start with a different range mid-dump.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                          input int stall_idx, input int stall_len,
                          input bit rnd, input bit poke);
    logic [N-1:0] d_q[$];
    logic [4:0]   n_q[$];
    bit           l_q[$];
    logic [N-1:0] sum;
    logic [4:0]   no;
    int cnt, idx, cyc, stall_left, exp_done_cyc;
    bit done_exp, finished, seen_first;

    cnt = (int'(l) - int'(f) + 32) % 32 + 1;
    sum = '0;
    for (int i = 0; i < cnt; i++) begin
      no = 5'((int'(f) + i) % 32);
      d_q.push_back(regs[no]);
      n_q.push_back(no);
      l_q.push_back(1'b0);
      sum = sum + regs[no];
    end
`ifdef GPR_DUMP_CHECKSUM_EN
    d_q.push_back(sum);
    n_q.push_back(l);
    l_q.push_back(1'b1);
    exp_done_cyc = 2 * cnt + 2;
`else
    l_q[cnt-1] = 1'b1;
    exp_done_cyc = 2 * cnt + 1;
`endif

    @(negedge clk_i);
    start_i = 1'b1; first_no_i = f; last_no_i = l; out_ready_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0; first_no_i = ~f; last_no_i = ~l;
    chk("fetch_busy", busy_o, 1);
    chk("fetch_valid", out_valid_o, 0);
    chk("fetch_rd_no", rd_no_o, f);

    cyc = 1; idx = 0; stall_left = stall_len;
    done_exp = 0; finished = 0; seen_first = 0;
    while (!finished && cyc < LIMIT) begin
      if (done_exp) begin
        chk("done_pulse", done_o, 1);
        chk("done_valid", out_valid_o, 0);
        if (!rnd && stall_len == 0) chk("done_cycle", cyc, exp_done_cyc);
        finished = 1;
      end else begin
        chk("done_early", done_o, 0);
        if (out_valid_o) begin
          if (!seen_first) begin
            chk("first_valid_cycle", cyc, 2);
            seen_first = 1;
          end
          if (idx < d_q.size()) begin
            chk("word_data", out_data_o, d_q[idx]);
            chk("word_no", out_no_o, n_q[idx]);
            chk("word_last", out_last_o, l_q[idx]);
          end
        end
        if (rnd) out_ready_i = 1'($urandom_range(0, 1));
        else if (out_valid_o && idx == stall_idx && stall_left > 0) begin
          out_ready_i = 1'b0;
          stall_left--;
        end else out_ready_i = 1'b1;
        if (out_valid_o && out_ready_i) begin
          idx++;
          if (idx == d_q.size()) done_exp = 1;
        end
        if (poke && cyc == 3) begin
          start_i = 1'b1; first_no_i = 5'd0; last_no_i = 5'd9;
        end else start_i = 1'b0;
        @(negedge clk_i);
        cyc++;
      end
    end
    chk("dump_finished", finished, 1);
    chk("word_count", idx, d_q.size());
    start_i = 1'b0;
    @(negedge clk_i);
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);
  endtask

  initial begin
    bit found;
    for (int r = 0; r < 32; r++) regs[r] = N'($urandom);
    reset_i = 1'b1; start_i = 1'b0; first_no_i = '0; last_no_i = '0; out_ready_i = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk_i);
    reset_i = 1'b0;

    // Basic dump, then with a 3-cycle stall on the second word
    regs[1] = 8'd10; regs[2] = 8'd11; regs[3] = 8'd12; regs[4] = 8'd13;
    run_dump(5'd1, 5'd4, -1, 0, 0, 0);
    run_dump(5'd1, 5'd4, 1, 3, 0, 0);

    // Wrap through register 31
    regs[30] = 8'h01; regs[31] = 8'h02; regs[0] = 8'h03; regs[1] = 8'h04;
    run_dump(5'd30, 5'd1, -1, 0, 0, 0);

    // Single word, and a two-word range whose sum wraps
    regs[5] = 8'hFF; regs[6] = 8'h02;
    run_dump(5'd5, 5'd5, -1, 0, 0, 0);
    run_dump(5'd5, 5'd6, -1, 0, 0, 0);

    // Reset while word 2 is being presented
    regs[1] = 8'd10;
    @(negedge clk_i);
    start_i = 1'b1; first_no_i = 5'd1; last_no_i = 5'd4; out_ready_i = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (out_valid_o && out_no_o == 5'd2) begin
        found = 1;
        out_ready_i = 1'b0;
      end
    end
    chk("reach_word2", found, 1);
    #2 reset_i = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(negedge clk_i);
    @(negedge clk_i);
    chk("midreset_done", done_o, 0);
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("post_reset_busy", busy_o, 0);
      chk("post_reset_done", done_o, 0);
    end
    run_dump(5'd1, 5'd4, -1, 0, 0, 0);

    // start while busy must be ignored
    run_dump(5'd1, 5'd4, -1, 0, 0, 1);

    // Random ranges, contents and back-pressure
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < 32; r++) regs[r] = N'($urandom);
      run_dump(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), -1, 0, 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpr_dump.md
# gpr_dump

Sequential read-out engine for the picoMIPS general-purpose register file. On a start pulse it walks a range of register numbers, drives each onto the register file's read-address port, captures the returned value and streams it out over a valid/ready handshake. It is the read-side counterpart of the write traffic applied to `regs`, and is used for debug dump, scan-out and register-file self-check.

## Interface

- `n`, 8, data width; matches `regs` `n`

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a dump; sampled only in IDLE
- `first_no`  in  5  first register number; sampled with `start`
- `last_no`  in  5  last register number; sampled with `start`
- `rd_no`  out  5  read address to `regs` (drives its `Rsno`)
- `rd_data`  in  n  read data from `regs` (`Rs`, combinational read)
- `out_data`  out  n  streamed register value
- `out_no`  out  5  register number of `out_data`
- `out_valid`  out  1  `out_data`/`out_no`/`out_last` valid
- `out_ready`  in  1  consumer accepts word when high with `out_valid`
- `out_last`  out  1  high on the final word of a dump
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse after final word accepted

## Operation

- States: IDLE, FETCH, SEND, SUM (only with macro), DONE.
- IDLE: `start`=1 loads `ptr`<=`first_no`, `end`<=`last_no`, `acc`<=0; -> FETCH.
- FETCH: `rd_no`=`ptr`; at clock edge `out_data`<=`rd_data`, `out_no`<=`ptr`, `acc`<=`acc`+`rd_data`; -> SEND.
- SEND: `out_valid`=1. On `out_valid && out_ready`: if `ptr`==`end` -> SUM (macro) or DONE; else `ptr`<=`ptr`+1 -> FETCH.
- DONE: `done`=1 for exactly one cycle; -> IDLE.
- `rd_no` = `ptr` in all states; `ptr` increments modulo 32 (31 wraps to 0).
- Word count = ((`last_no` - `first_no`) mod 32) + 1; `first_no`==`last_no` gives one word; `first_no`>`last_no` wraps through 31.
- `out_last`=1 in SEND only on the final data word (without macro) or only in SUM (with macro).
- `out_data`/`out_no` held stable while `out_valid`=1 and `out_ready`=0.
- `start` while `busy` is ignored; `first_no`/`last_no` changes after the start cycle are ignored.
- Block never writes the register file.

## Timing

- Reset (async, immediate): state IDLE; `rd_no`, `out_data`, `out_no`, `out_valid`, `out_last`, `busy`, `done`, `acc` all 0.
- Reset asserted mid-dump: in-flight word dropped, no `done`; dump restarts only on a fresh `start`.
- `start` at edge k -> FETCH in cycle k+1 -> first `out_valid` in cycle k+2.
- With `out_ready` held 1: one word every 2 cycles; `done` one cycle after the last accepted word.
- Minimum 1-word dump: start-to-`done` = 4 cycles (5 with macro).
- `rd_data` must settle within the FETCH cycle (single-cycle combinational read path).

## Configuration

- `GPR_DUMP_CHECKSUM_EN` defined: after the last data word, SUM state presents `out_data`=`acc` (sum of all emitted words mod 2^n), `out_no`=`end`, `out_last`=1, `out_valid`=1; handshake as SEND; then DONE.
- Not defined: no SUM state, no `acc` register; `out_last` marks the last data word.

## Test plan

- Bench writes regs 1..4 = 10,11,12,13; dump 1..4, `out_ready`=1 -> words 10,11,12,13 with `out_no` 1..4, `out_last` on 13, `done` 2 cycles after... exactly one cycle after the 13 handshake; with macro an extra word 46 (0x2E) with `out_last`.
- Same dump, `out_ready` low 3 cycles on word 11 -> `out_data`=11 and `out_no`=2 held stable; no word lost or duplicated.
- Regs 30,31,0,1 = 0x01,0x02,0x03,0x04; dump `first_no`=30, `last_no`=1 -> order 30,31,0,1, four words; checksum 0x0A with macro.
- `first_no`=`last_no`=5, reg5=0xFF -> one word 0xFF with `out_last`; checksum word 0xFF with macro; sums 0xFF+0x02 wrap to 0x01.
- `reset` pulsed while in SEND of word 2 -> all outputs 0 immediately, no `done`; next `start` dumps from `first_no` cleanly.
- `start` pulsed while `busy` with different range -> ignored; original range completes unchanged.
